game_seq: RTL and testbench

Game-flow sequencer for the VGA box/board game. Derives a once-per-frame step strobe from the display's vertical sync, runs the attract/play/miss/game-over state machine, and tracks score and lives. It gates the box and board movement datapath through `move_en`, re-initialises object positions through `game_clr`, and presents `score` and `lives` for on-screen display.

---
 rtl/game_seq.sv | 139 +++++++++++++
 tb/tb_game_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/game_seq.sv
// Game-flow sequencer: turns vsync into a frame strobe and runs the
// attract/play/miss/game-over flow, tracking score and lives.
module game_seq #(
  parameter int LIVES       = 3,
  parameter int MISS_FRAMES = 60,
  parameter int SCORE_MAX   = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        button_left,
  input  logic        button_right,
  input  logic        bottom_hit,
  input  logic        board_hit,
  output logic        frame_tick,
  output logic        move_en,
  output logic        game_clr,
  output logic [1:0]  state,
  output logic [2:0]  lives,
  output logic [15:0] score
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_MISS = 2'd2,
    S_OVER = 2'd3
  } state_t;

  localparam logic [2:0]  LIVES_INIT = 3'(LIVES);
  localparam logic [7:0]  MISS_LOAD  = 8'(MISS_FRAMES - 1);
  localparam logic [15:0] SCORE_SAT  = 16'(SCORE_MAX);

  state_t      state_q, state_d;
  logic        vs_q, tick_q;
  logic        btn_q, bh_q, bt_q;
  logic        move_q, move_d;
  logic        clr_q, clr_d;
  logic [2:0]  lives_q, lives_d;
  logic [15:0] score_q, score_d;
  logic [7:0]  miss_q, miss_d;

  logic btn_now, press, bh_rise, bt_rise;

  assign btn_now = ~button_left | ~button_right;
  assign press   = btn_now & ~btn_q;
  assign bh_rise = board_hit & ~bh_q;
  assign bt_rise = bottom_hit & ~bt_q;

  always_comb begin
    // NOTE: every next-state signal gets its default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    lives_d = lives_q;
    score_d = score_q;
    miss_d  = miss_q;
    clr_d   = 1'b0;
    if (tick_q) begin
      unique case (state_q)
        S_IDLE: begin
          if (press) begin
            clr_d   = 1'b1;
            score_d = '0;
            lives_d = LIVES_INIT;
            state_d = S_PLAY;
          end
        end
        S_PLAY: begin
          // A miss on the same tick as a board hit takes priority; score is untouched.
          if (bt_rise) begin
            if (lives_q <= 3'd1) begin
              lives_d = '0;
              state_d = S_OVER;
            end else begin
              lives_d = lives_q - 3'd1;
              miss_d  = MISS_LOAD;
              state_d = S_MISS;
            end
          end else if (bh_rise && (score_q < SCORE_SAT)) begin
            score_d = score_q + 16'd1;
          end
        end
        S_MISS: begin
          if (miss_q == 8'd0) begin
            clr_d   = 1'b1;
            state_d = S_PLAY;
          end else begin
            miss_d = miss_q - 8'd1;
          end
        end
        S_OVER: begin
          if (press) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    // The frame that reloads positions does not also step them.
    move_d = tick_q && (state_d == S_PLAY) && !clr_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      vs_q    <= 1'b1;
      tick_q  <= 1'b0;
      btn_q   <= 1'b1;
      bh_q    <= 1'b1;
      bt_q    <= 1'b1;
      state_q <= S_IDLE;
      lives_q <= LIVES_INIT;
      score_q <= '0;
      miss_q  <= '0;
      move_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      vs_q   <= vsync;
      tick_q <= vsync & ~vs_q;
      // History tracks every tick, so entering PLAY always starts from the current levels.
      if (tick_q) begin
        btn_q <= btn_now;
        bh_q  <= board_hit;
        bt_q  <= bottom_hit;
      end
      state_q <= state_d;
      lives_q <= lives_d;
      score_q <= score_d;
      miss_q  <= miss_d;
      move_q  <= move_d;
      clr_q   <= clr_d;
    end
  end

  assign frame_tick = tick_q;
  assign move_en    = move_q;
  assign game_clr   = clr_q;
  assign state      = state_q;
  assign lives      = lives_q;
  assign score      = score_q;

endmodule

// File: tb/tb_game_seq.sv
// Self-checking bench for game_seq: reset/tick timing, a per-frame vector table
// covering a full game, and a reset landing on a tick edge during MISS.
module tb_game_seq;

  logic        clk = 1'b0;
  logic        rst, vsync, button_left, button_right, bottom_hit, board_hit;
  logic        frame_tick, move_en, game_clr;
  logic [1:0]  state;
  logic [2:0]  lives;
  logic [15:0] score;
  logic        s_tick, s_move, s_clr;
  logic [1:0]  s_state;
  logic [2:0]  s_lives;
  logic [15:0] s_score;

  int total  = 0;
  int passed = 0;
  int tick_cnt = 0, move_cnt = 0, clr_cnt = 0, overlap_cnt = 0;

  always #5 clk = ~clk;

  game_seq #(.LIVES(3), .MISS_FRAMES(4), .SCORE_MAX(9999)) dut (
    .clk(clk), .rst(rst), .vsync(vsync),
    .button_left(button_left), .button_right(button_right),
    .bottom_hit(bottom_hit), .board_hit(board_hit),
    .frame_tick(frame_tick), .move_en(move_en), .game_clr(game_clr),
    .state(state), .lives(lives), .score(score)
  );

  // Same stimulus, small saturation value.
  game_seq #(.LIVES(3), .MISS_FRAMES(4), .SCORE_MAX(3)) dut_sat (
    .clk(clk), .rst(rst), .vsync(vsync),
    .button_left(button_left), .button_right(button_right),
    .bottom_hit(bottom_hit), .board_hit(board_hit),
    .frame_tick(s_tick), .move_en(s_move), .game_clr(s_clr),
    .state(s_state), .lives(s_lives), .score(s_score)
  );

  always @(negedge clk) begin
    if (frame_tick) tick_cnt++;
    if (move_en) move_cnt++;
    if (game_clr) clr_cnt++;
    if (game_clr && move_en) overlap_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  typedef struct {
    logic       bl, br, bh, bt;
    logic [1:0] st;
    logic [2:0] lv;
    int         sc, clr, mv;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic bl, br, bh, bt, input logic [1:0] st,
                     input logic [2:0] lv, input int sc, clr, mv);
    vec_t v;
    v.bl = bl; v.br = br; v.bh = bh; v.bt = bt;
    v.st = st; v.lv = lv; v.sc = sc; v.clr = clr; v.mv = mv;
    vecs.push_back(v);
  endtask

  // One frame: inputs held, vsync high 3 cycles then low 4.
  task automatic run_frame(input logic bl, br, bh, bt);
    @(negedge clk);
    button_left = bl; button_right = br; board_hit = bh; bottom_hit = bt;
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    repeat (4) @(negedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, m0, c0;
    rst = 1'b1; vsync = 1'b1;
    button_left = 1'b1; button_right = 1'b1; board_hit = 1'b0; bottom_hit = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_lives", lives, 3);
    check("rst_score", score, 0);
    check("rst_tick", frame_tick, 0);
    check("rst_move", move_en, 0);
    check("rst_clr", game_clr, 0);

    t0 = tick_cnt;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("no_tick_after_release", tick_cnt - t0, 0);

    vsync = 1'b0;
    repeat (400) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      t0 = tick_cnt;
      vsync = 1'b1;
      @(negedge clk);
      check($sformatf("tick_rise_%0d", p), frame_tick, 1);
      @(negedge clk);
      check($sformatf("tick_width_%0d", p), frame_tick, 0);
      repeat (398) @(negedge clk);
      vsync = 1'b0;
      repeat (400) @(negedge clk);
      check($sformatf("tick_once_%0d", p), tick_cnt - t0, 1);
    end

    //  bl    br    bh    bt    state lives score clr move
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd3, 0, 0, 0); // 0 idle
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 3'd3, 0, 1, 0); // 1 start
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 3'd3, 0, 0, 1); // 2 held button
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 3'd3, 0, 0, 1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 3'd3, 1, 0, 1); // 4 hits
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 3'd3, 1, 0, 1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 3'd3, 2, 0, 1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 3'd3, 2, 0, 1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 3'd3, 3, 0, 1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 3'd3, 3, 0, 1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 3'd3, 4, 0, 1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 3'd3, 4, 0, 1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 3'd3, 5, 0, 1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 3'd3, 5, 0, 1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 3'd3, 6, 0, 1); // 14 held 4 frames
    add(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 3'd3, 6, 0, 1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 3'd3, 6, 0, 1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 3'd3, 6, 0, 1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 3'd3, 6, 0, 1);
    add(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 3'd2, 6, 0, 0); // 19 miss
    add(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 3'd2, 6, 0, 0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 3'd2, 6, 0, 0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 3'd2, 6, 0, 0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 3'd2, 6, 1, 0); // 23 resume
    add(1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 3'd1, 6, 0, 0); // 24 both rise
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 3'd1, 6, 0, 0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 3'd1, 6, 0, 0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 3'd1, 6, 0, 0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 3'd1, 6, 1, 0); // 28 resume, hit already high
    add(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 3'd1, 6, 0, 1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 3'd1, 6, 0, 1);
    add(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 3'd0, 6, 0, 0); // 31 game over
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 3'd0, 6, 0, 0);
    add(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 3'd0, 6, 0, 0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 6, 0, 0); // 34 back to idle
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 6, 0, 0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'd3, 0, 1, 0); // 36 new game
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 3'd3, 0, 0, 1);

    foreach (vecs[i]) begin
      m0 = move_cnt; c0 = clr_cnt;
      run_frame(vecs[i].bl, vecs[i].br, vecs[i].bh, vecs[i].bt);
      check($sformatf("v%0d_state", i), state, vecs[i].st);
      check($sformatf("v%0d_lives", i), lives, vecs[i].lv);
      check($sformatf("v%0d_score", i), score, vecs[i].sc);
      check($sformatf("v%0d_clr", i), clr_cnt - c0, vecs[i].clr);
      check($sformatf("v%0d_move", i), move_cnt - m0, vecs[i].mv);
      check($sformatf("v%0d_sat_score", i), s_score, (vecs[i].sc > 3) ? 3 : vecs[i].sc);
    end

    // Reset lands on the tick edge while in MISS with miss_cnt = 2.
    run_frame(1'b1, 1'b1, 1'b0, 1'b1);
    check("mr_miss_state", state, 2);
    run_frame(1'b1, 1'b1, 1'b0, 1'b0);
    check("mr_miss_lives", lives, 2);
    c0 = clr_cnt;
    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    check("mr_tick_pending", frame_tick, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_state", state, 0);
    check("mr_lives", lives, 3);
    check("mr_score", score, 0);
    check("mr_tick", frame_tick, 0);
    check("mr_move", move_en, 0);
    check("mr_clr", game_clr, 0);
    vsync = 1'b0;
    repeat (4) @(negedge clk);
    run_frame(1'b1, 1'b1, 1'b0, 1'b0);
    check("mr_stay_idle", state, 0);
    check("mr_no_clr", clr_cnt - c0, 0);
    check("clr_move_overlap", overlap_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
